// File: rtl/cbc_block_feeder.sv
// -----------------------------------------------------------------------------
// cbc_block_feeder
//
// Packs an AXI-Stream-like pixel byte stream into BLOCK_SIZE-bit plaintext
// blocks and hands them, together with the CBC chaining value, to an external
// block encryptor. Each returned ciphertext becomes the chaining value (IV) of
// the next block; the chain persists across frames unless reloaded via
// iv_load while idle. A short final block (pix_tlast before the block is full)
// is zero-padded.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : synchronous, active-high
//   iv_load      : load iv_in into the chain register (honoured in IDLE only)
//   iv_in        : initial vector for a new frame
//   pix_tvalid   : pixel byte valid
//   pix_tdata    : pixel byte
//   pix_tlast    : last byte of frame
//   pix_tready   : byte accepted when pix_tvalid && pix_tready (state only)
//   encr_tvalid  : one-cycle pulse, plaintext/iv valid for the encryptor
//   plaintext    : packed block, first byte in the MSBs
//   iv           : chaining value for the current block
//   encr_valid   : encryptor done pulse
//   ciphertext   : encryptor result, sampled on encr_valid in WAIT
//   block_count  : blocks completed since reset (wrapping)
//   frame_done   : one-cycle pulse when the last block of a frame completes
// -----------------------------------------------------------------------------
module cbc_block_feeder #(
  parameter int BLOCK_SIZE = 256,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iv_load,
  input  logic [BLOCK_SIZE-1:0] iv_in,
  input  logic                  pix_tvalid,
  input  logic [7:0]            pix_tdata,
  input  logic                  pix_tlast,
  output logic                  pix_tready,
  output logic                  encr_tvalid,
  output logic [BLOCK_SIZE-1:0] plaintext,
  output logic [BLOCK_SIZE-1:0] iv,
  input  logic                  encr_valid,
  input  logic [BLOCK_SIZE-1:0] ciphertext,
  output logic [CNT_W-1:0]      block_count,
  output logic                  frame_done
);

  localparam int N     = BLOCK_SIZE / 8;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [IDX_W-1:0]      idx_r;
  logic [BLOCK_SIZE-1:0] chain_r;
  logic [BLOCK_SIZE-1:0] plaintext_r;
  logic                  last_blk_r;
  logic                  frame_done_r;
  logic [CNT_W-1:0]      count_r;

  logic                  ready_s;
  logic                  accept_s;
  logic                  blk_end_s;
  logic                  done_s;

  // Readiness depends on state only, so there is no path from pix_tvalid.
  assign ready_s   = (state_r == IDLE) || (state_r == FILL);
  assign accept_s  = pix_tvalid && ready_s;
  // A block closes on its last byte slot or on any byte flagged as frame end.
  assign blk_end_s = accept_s && ((idx_r == IDX_W'(N - 1)) || pix_tlast);
  // encr_valid only counts while a block is outstanding.
  assign done_s    = (state_r == WAIT) && encr_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        // A one-byte frame goes straight to ISSUE to keep the T+1 latency.
        if (accept_s) begin
          state_s = blk_end_s ? ISSUE : FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (blk_end_s) begin
          state_s = ISSUE;
        end else begin
          state_s = FILL;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (encr_valid) begin
          state_s = last_blk_r ? IDLE : FILL;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Byte packing: index, plaintext assembly and frame-last flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r       <= '0;
      plaintext_r <= '0;
      last_blk_r  <= 1'b0;
    end else if (accept_s) begin
      // Clearing on the first byte zero-pads any short final block; the byte
      // write below overrides the cleared MSB lane.
      if (idx_r == '0) begin
        plaintext_r <= '0;
      end
      for (int k = 0; k < N; k++) begin
        if (idx_r == IDX_W'(k)) begin
          plaintext_r[BLOCK_SIZE-1-8*k -: 8] <= pix_tdata;
        end
      end
      if (blk_end_s) begin
        idx_r      <= '0;
        last_blk_r <= pix_tlast;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end
  end

  // CBC chain register: IV load while idle, ciphertext feedback on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_r <= '0;
    end else if ((state_r == IDLE) && iv_load) begin
      chain_r <= iv_in;
    end else if (done_s) begin
      chain_r <= ciphertext;
    end
  end

  // Completion bookkeeping: wrapping block counter and frame-done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r      <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= done_s && last_blk_r;
      if (done_s) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign pix_tready  = ready_s;
  assign encr_tvalid = (state_r == ISSUE);
  assign plaintext   = plaintext_r;
  assign iv          = chain_r;
  assign block_count = count_r;
  assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_cbc_block_feeder.sv
module tb_cbc_block_feeder;

  localparam int BS = 256;
  localparam int CW = 4;
  localparam int NB = BS / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          iv_load;
  logic [BS-1:0] iv_in;
  logic          pix_tvalid;
  logic [7:0]    pix_tdata;
  logic          pix_tlast;
  logic          pix_tready;
  logic          encr_tvalid;
  logic [BS-1:0] plaintext;
  logic [BS-1:0] iv;
  logic          encr_valid;
  logic [BS-1:0] ciphertext;
  logic [CW-1:0] block_count;
  logic          frame_done;

  always #5 clk = ~clk;

  cbc_block_feeder #(.BLOCK_SIZE(BS), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .iv_load(iv_load), .iv_in(iv_in),
    .pix_tvalid(pix_tvalid), .pix_tdata(pix_tdata), .pix_tlast(pix_tlast),
    .pix_tready(pix_tready), .encr_tvalid(encr_tvalid), .plaintext(plaintext),
    .iv(iv), .encr_valid(encr_valid), .ciphertext(ciphertext),
    .block_count(block_count), .frame_done(frame_done)
  );

  typedef struct {
    logic [BS-1:0] pt;
    logic [BS-1:0] iv;
    logic [BS-1:0] c;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [BS-1:0] model_chain = '0;
  logic [CW-1:0] exp_count = '0;
  int            exp_blocks = 0;
  int            blocks_done = 0;
  int            exp_frames = 0;
  int            frames_seen = 0;
  int            spur_req = 0;
  int            spur_done = 0;

  // Frame-done pulse counter.
  always @(negedge clk) begin
    if (frame_done === 1'b1) frames_seen++;
  end

  // Encryptor model: checks each issued block against the scoreboard, checks
  // hold behaviour while waiting, then returns the scheduled ciphertext.
  initial begin : responder
    int   wait_cnt;
    bit   spur_pulse;
    exp_t cur;
    encr_valid = 1'b0;
    ciphertext = '0;
    wait_cnt   = 0;
    spur_pulse = 1'b0;
    forever begin
      @(negedge clk);
      if (encr_valid) begin
        encr_valid = 1'b0;
        if (!spur_pulse) blocks_done++;
        spur_pulse = 1'b0;
      end else if (wait_cnt > 0) begin
        checks++;
        if (plaintext !== cur.pt || iv !== cur.iv) begin
          errors++;
          $display("FAIL hold: plaintext %h iv %h, required %h / %h", plaintext, iv, cur.pt, cur.iv);
        end
        checks++;
        if (pix_tready !== 1'b0 || encr_tvalid !== 1'b0) begin
          errors++;
          $display("FAIL wait_flags: tready %b tvalid %b, required 0 0", pix_tready, encr_tvalid);
        end
        wait_cnt--;
        if (wait_cnt == 0) begin
          encr_valid = 1'b1;
          ciphertext = cur.c;
        end
      end else if (encr_tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_pulse: encr_tvalid 1, required 0");
          cur.pt = plaintext;
          cur.iv = iv;
          cur.c  = '0;
        end else begin
          cur = exp_q.pop_front();
          checks++;
          if (plaintext !== cur.pt) begin
            errors++;
            $display("FAIL plaintext: got %h required %h", plaintext, cur.pt);
          end
          checks++;
          if (iv !== cur.iv) begin
            errors++;
            $display("FAIL iv: got %h required %h", iv, cur.iv);
          end
          checks++;
          if (pix_tready !== 1'b0) begin
            errors++;
            $display("FAIL issue_tready: got %b required 0", pix_tready);
          end
        end
        wait_cnt = int'($urandom_range(1, 4));
      end else if (spur_req != spur_done) begin
        encr_valid = 1'b1;
        ciphertext = {NB{8'h5A}};
        spur_pulse = 1'b1;
        spur_done++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pix_tvalid = 1'b0; pix_tlast = 1'b0; iv_load = 1'b0;
    @(negedge clk);
    checks++;
    if (encr_tvalid !== 1'b0 || frame_done !== 1'b0 || iv !== '0 || plaintext !== '0 || block_count !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tvalid %b done %b iv %h pt %h count %0d, required all zero",
               encr_tvalid, frame_done, iv, plaintext, block_count);
    end
    reset = 1'b0;
    model_chain = '0;
    exp_count = '0;
    @(negedge clk);
    checks++;
    if (pix_tready !== 1'b1 || encr_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: tready %b tvalid %b, required 1 0", pix_tready, encr_tvalid);
    end
  endtask

  // Pushes expected blocks (when the frame is terminated) and drives the bytes,
  // holding each byte until accepted; checks encr_tvalid the cycle after every
  // block-final byte.
  task automatic send_frame(input logic [7:0] data[$], input bit with_last, input bit do_load,
                            input logic [BS-1:0] ivv, input logic [7:0] cbase);
    int   n;
    int   nblk;
    int   i;
    int   budget;
    bit   first;
    bit   chk;
    logic rdy;
    logic [7:0] cb;
    exp_t e;
    n = data.size();
    if (do_load) model_chain = ivv;
    if (with_last) begin
      nblk = (n + NB - 1) / NB;
      for (int b = 0; b < nblk; b++) begin
        e.pt = '0;
        for (int k = 0; k < NB; k++) begin
          if (b * NB + k < n) e.pt[BS-1-8*k -: 8] = data[b * NB + k];
        end
        e.iv = model_chain;
        cb = cbase + 8'(b);
        e.c = {NB{cb}};
        exp_q.push_back(e);
        model_chain = e.c;
      end
      exp_blocks += nblk;
      exp_count = exp_count + CW'(nblk);
      exp_frames++;
    end
    @(negedge clk);
    i = 0; first = 1'b1; budget = 0;
    iv_in = ivv;
    while (i < n && budget < 5000) begin
      pix_tvalid = 1'b1;
      pix_tdata  = data[i];
      pix_tlast  = with_last && (i == n - 1);
      iv_load    = do_load && first;
      rdy = pix_tready;
      @(posedge clk);
      first = 1'b0;
      budget++;
      if (rdy === 1'b1) begin
        i++;
        chk = (i % NB == 0) || (with_last && i == n);
      end else begin
        chk = 1'b0;
      end
      @(negedge clk);
      iv_load = 1'b0;
      if (chk) begin
        checks++;
        if (encr_tvalid !== 1'b1) begin
          errors++;
          $display("FAIL latency: encr_tvalid %b after block-final byte %0d, required 1", encr_tvalid, i - 1);
        end
      end
    end
    pix_tvalid = 1'b0; pix_tlast = 1'b0; iv_load = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: accepted %0d bytes, required %0d", i, n);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (blocks_done != exp_blocks && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (blocks_done != exp_blocks) begin
      errors++;
      $display("FAIL done_timeout: completed %0d blocks, required %0d", blocks_done, exp_blocks);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (block_count !== exp_count) begin
      errors++;
      $display("FAIL block_count: got %0d required %0d", block_count, exp_count);
    end
    checks++;
    if (frames_seen != exp_frames) begin
      errors++;
      $display("FAIL frame_done_count: got %0d required %0d", frames_seen, exp_frames);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulse: %0d blocks not issued, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single_block();
    logic [7:0] q[$];
    for (int k = 0; k < 32; k++) q.push_back(8'(k));
    send_frame(q, 1'b1, 1'b1, {NB{8'h11}}, 8'hC0);
    wait_done();
  endtask

  task automatic test_two_blocks();
    logic [7:0] q[$];
    do_reset();
    for (int k = 0; k < 64; k++) q.push_back(8'(k));
    send_frame(q, 1'b1, 1'b1, {NB{8'h11}}, 8'hAA);
    wait_done();
    checks++;
    if (block_count !== 4'd2) begin
      errors++;
      $display("FAIL two_block_count: got %0d required 2", block_count);
    end
  endtask

  task automatic test_short_block();
    logic [7:0] q[$];
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
    send_frame(q, 1'b1, 1'b0, '0, 8'h30);
    wait_done();
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    for (int k = 0; k < 40; k++) q.push_back(8'($urandom_range(0, 255)));
    send_frame(q, 1'b1, 1'b1, {NB{8'h3C}}, 8'h70);
    wait_done();
  endtask

  task automatic test_spurious();
    logic [7:0] q[$];
    int t;
    spur_req++;
    t = 0;
    while (spur_done != spur_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (block_count !== exp_count || iv !== model_chain) begin
      errors++;
      $display("FAIL spurious: count %0d iv %h, required %0d / %h", block_count, iv, exp_count, model_chain);
    end
    q = '{8'h55, 8'h66, 8'h77};
    send_frame(q, 1'b1, 1'b0, '0, 8'h90);
    wait_done();
  endtask

  task automatic test_midblock_reset();
    logic [7:0] q[$];
    for (int k = 0; k < 10; k++) q.push_back(8'(8'hE0 + 8'(k)));
    send_frame(q, 1'b0, 1'b1, {NB{8'h99}}, 8'h00);
    checks++;
    if (pix_tready !== 1'b1 || encr_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL partial_fill: tready %b tvalid %b, required 1 0", pix_tready, encr_tvalid);
    end
    do_reset();
    spur_req++;
    repeat (4) @(negedge clk);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(q, 1'b1, 1'b0, '0, 8'h20);
    wait_done();
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    do_reset();
    for (int j = 0; j < 16; j++) begin
      q = '{8'(j)};
      send_frame(q, 1'b1, (j == 0), {NB{8'h42}}, 8'(8'h10 + 8'(j)));
      wait_done();
    end
    checks++;
    if (block_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap: block_count %0d required 0", block_count);
    end
  endtask

  initial begin
    reset = 1'b1; iv_load = 1'b0; iv_in = '0;
    pix_tvalid = 1'b0; pix_tdata = 8'h00; pix_tlast = 1'b0;
    test_reset();
    test_single_block();
    test_two_blocks();
    test_short_block();
    test_back_to_back();
    test_spurious();
    test_midblock_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
